// File: rtl/pc_fetch_gen.sv
// IF-stage PC generator: fetch PC, imem request, redirect arbitration,
// stale-response kill and epoch-tagged IF/ID output registers.
module pc_fetch_gen #(
    parameter int              WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 'h60,
    parameter int              INSTR_BYTES  = 4,
    parameter int              EPOCH_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  redir_ex_valid,
    input  logic [WIDTH-1:0]      redir_ex_tgt,
    input  logic                  redir_id_valid,
    input  logic [WIDTH-1:0]      redir_id_tgt,
    output logic                  imem_req,
    output logic [WIDTH-1:0]      imem_addr,
    input  logic                  imem_resp,
    input  logic [WIDTH-1:0]      imem_rdata,
    output logic                  fetch_valid,
    output logic [WIDTH-1:0]      fetch_pc,
    output logic [WIDTH-1:0]      fetch_inst,
    output logic [EPOCH_BITS-1:0] fetch_epoch,
    output logic                  redir_misalign
);

    localparam logic [WIDTH-1:0] INC   = WIDTH'(INSTR_BYTES);
    localparam logic [WIDTH-1:0] ALIGN = WIDTH'(INSTR_BYTES - 1);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_HOLD
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [WIDTH-1:0]      pc_q;
    logic [WIDTH-1:0]      pc_d;
    logic                  pend_q;
    logic                  pend_d;
    logic [WIDTH-1:0]      pend_tgt_q;
    logic [WIDTH-1:0]      pend_tgt_d;
    logic [WIDTH-1:0]      held_q;
    logic [WIDTH-1:0]      held_d;
    logic [EPOCH_BITS-1:0] epoch_q;

    logic                  redir;
    logic [WIDTH-1:0]      tgt_raw;
    logic [WIDTH-1:0]      tgt;
    logic                  misalign;
    logic                  deliver;
    logic [WIDTH-1:0]      deliver_inst;

    // EX outranks ID; low bits are forced to instruction alignment
    assign redir    = redir_ex_valid | redir_id_valid;
    assign tgt_raw  = redir_ex_valid ? redir_ex_tgt : redir_id_tgt;
    assign tgt      = tgt_raw & ~ALIGN;
    assign misalign = |(tgt_raw & ALIGN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_resp && !redir && !pend_q && stall) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redir || !stall) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_comb begin
        imem_req  = (state_q == S_FETCH);
        imem_addr = pc_q;
    end

    // Datapath next-state; a redirect never moves pc while a request is open
    always_comb begin
        pc_d         = pc_q;
        pend_d       = pend_q;
        pend_tgt_d   = pend_tgt_q;
        held_d       = held_q;
        deliver      = 1'b0;
        deliver_inst = held_q;
        unique case (state_q)
            S_BOOT: begin
                if (redir) begin
                    pc_d = tgt;
                end
            end
            S_FETCH: begin
                if (!imem_resp) begin
                    if (redir) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = tgt;
                    end
                end else if (redir || pend_q) begin
                    pc_d   = redir ? tgt : pend_tgt_q;
                    pend_d = 1'b0;
                end else if (stall) begin
                    held_d = imem_rdata;
                end else begin
                    deliver      = 1'b1;
                    deliver_inst = imem_rdata;
                    pc_d         = pc_q + INC;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    pc_d = tgt;
                end else if (!stall) begin
                    deliver      = 1'b1;
                    deliver_inst = held_q;
                    pc_d         = pc_q + INC;
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            held_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            held_q     <= held_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epoch_q        <= '0;
            redir_misalign <= 1'b0;
            fetch_valid    <= 1'b0;
            fetch_pc       <= '0;
            fetch_inst     <= '0;
            fetch_epoch    <= '0;
        end else if (redir) begin
            epoch_q        <= epoch_q + EPOCH_BITS'(1);
            redir_misalign <= misalign;
            fetch_valid    <= 1'b0;
        end else begin
            redir_misalign <= 1'b0;
            if (!stall) begin
                fetch_valid <= deliver;
                if (deliver) begin
                    fetch_pc    <= pc_q;
                    fetch_inst  <= deliver_inst;
                    fetch_epoch <= epoch_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Directed bench for pc_fetch_gen: expected IF/ID entries go to a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_pc_fetch_gen;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redir_ex_valid;
    logic [31:0] redir_ex_tgt;
    logic        redir_id_valid;
    logic [31:0] redir_id_tgt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic [1:0]  fetch_epoch;
    logic        redir_misalign;

    logic        ovr_en;
    logic [31:0] ovr_data;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  epoch;
    } entry_t;

    entry_t exp_q[$];
    int     total;
    int     bad;
    logic   ld_edge;

    pc_fetch_gen dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redir_ex_valid (redir_ex_valid),
        .redir_ex_tgt   (redir_ex_tgt),
        .redir_id_valid (redir_id_valid),
        .redir_id_tgt   (redir_id_tgt),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_resp      (imem_resp),
        .imem_rdata     (imem_rdata),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .fetch_inst     (fetch_inst),
        .fetch_epoch    (fetch_epoch),
        .redir_misalign (redir_misalign)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = ovr_en ? ovr_data : mem_word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst,
                        input logic [1:0] ep);
        entry_t e;
        e.pc    = pc;
        e.inst  = inst;
        e.epoch = ep;
        exp_q.push_back(e);
    endtask

    // An entry is new only if the output regs were allowed to load
    always @(posedge clk) ld_edge = !stall && !rst;

    always @(negedge clk) begin
        if (!rst && fetch_valid && ld_edge) begin
            entry_t e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got pc=0x%08h inst=0x%08h ep=%0d want none",
                         fetch_pc, fetch_inst, fetch_epoch);
            end else begin
                e = exp_q.pop_front();
                if (fetch_pc !== e.pc || fetch_inst !== e.inst ||
                    fetch_epoch !== e.epoch) begin
                    bad++;
                    $display("FAIL sb_entry: got pc=0x%08h inst=0x%08h ep=%0d want pc=0x%08h inst=0x%08h ep=%0d",
                             fetch_pc, fetch_inst, fetch_epoch, e.pc, e.inst, e.epoch);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b0;
        stall          = 1'b0;
        redir_ex_valid = 1'b0;
        redir_ex_tgt   = '0;
        redir_id_valid = 1'b0;
        redir_id_tgt   = '0;
        imem_resp      = 1'b0;
        ovr_en         = 1'b0;
        ovr_data       = '0;
        #1 rst = 1'b1;
        #2;
        chk("rst_addr", imem_addr, 32'h60);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(fetch_valid), 32'd0);
        chk("rst_pc", fetch_pc, 32'd0);
        chk("rst_misalign", 32'(redir_misalign), 32'd0);
        step();
        step();

        // sequential fetch with zero-wait memory
        rst       = 1'b0;
        imem_resp = 1'b1;
        push(32'h60, mem_word(32'h60), 2'd0);
        push(32'h64, mem_word(32'h64), 2'd0);
        push(32'h68, mem_word(32'h68), 2'd0);
        chk("boot_req", 32'(imem_req), 32'd0);
        step();
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h60);
        step();
        step();
        step();

        // redirect while request at 0x6C outstanding
        imem_resp      = 1'b0;
        redir_id_valid = 1'b1;
        redir_id_tgt   = 32'h200;
        step();
        chk("pend_addr", imem_addr, 32'h6C);
        chk("pend_valid", 32'(fetch_valid), 32'd0);
        redir_id_valid = 1'b0;
        step();
        step();
        imem_resp = 1'b1;
        step();
        chk("kill_addr", imem_addr, 32'h200);
        chk("kill_valid", 32'(fetch_valid), 32'd0);
        push(32'h200, mem_word(32'h200), 2'd1);
        step();

        // EX and ID together, with stall: EX wins, epoch +1
        redir_ex_valid = 1'b1;
        redir_ex_tgt   = 32'h300;
        redir_id_valid = 1'b1;
        redir_id_tgt   = 32'h400;
        stall          = 1'b1;
        step();
        chk("prio_addr", imem_addr, 32'h300);
        chk("prio_valid", 32'(fetch_valid), 32'd0);
        redir_ex_valid = 1'b0;
        redir_id_valid = 1'b0;
        stall          = 1'b0;
        push(32'h300, mem_word(32'h300), 2'd2);
        step();

        // response under stall parks in HOLD
        stall    = 1'b1;
        ovr_en   = 1'b1;
        ovr_data = 32'hDEAD_BEEF;
        step();
        chk("hold_req", 32'(imem_req), 32'd0);
        imem_resp = 1'b0;
        ovr_en    = 1'b0;
        step();
        chk("hold_keep_valid", 32'(fetch_valid), 32'd1);
        chk("hold_keep_pc", fetch_pc, 32'h300);
        step();
        stall = 1'b0;
        push(32'h304, 32'hDEAD_BEEF, 2'd2);
        step();
        chk("after_hold_addr", imem_addr, 32'h308);
        chk("after_hold_req", 32'(imem_req), 32'd1);

        // misaligned target, then epoch wrap 3 -> 0
        redir_ex_valid = 1'b1;
        redir_ex_tgt   = 32'h103;
        step();
        chk("mis_pulse", 32'(redir_misalign), 32'd1);
        chk("mis_addr_held", imem_addr, 32'h308);
        redir_ex_valid = 1'b0;
        imem_resp      = 1'b1;
        step();
        chk("mis_clear", 32'(redir_misalign), 32'd0);
        chk("mis_addr", imem_addr, 32'h100);
        push(32'h100, mem_word(32'h100), 2'd3);
        step();
        redir_id_valid = 1'b1;
        redir_id_tgt   = 32'h500;
        step();
        chk("wrap_redir_addr", imem_addr, 32'h500);
        redir_id_valid = 1'b0;
        push(32'h500, mem_word(32'h500), 2'd0);
        step();

        // async reset while in HOLD
        stall = 1'b1;
        step();
        chk("hold2_req", 32'(imem_req), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(fetch_valid), 32'd0);
        chk("arst_addr", imem_addr, 32'h60);
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_epoch", 32'(fetch_epoch), 32'd0);
        stall = 1'b0;
        step();
        step();

        // redirect in BOOT to the top of the address space, then wrap
        rst            = 1'b0;
        redir_id_valid = 1'b1;
        redir_id_tgt   = 32'hFFFF_FFFC;
        step();
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        chk("top_req", 32'(imem_req), 32'd1);
        redir_id_valid = 1'b0;
        push(32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 2'd1);
        push(32'h0, mem_word(32'h0), 2'd1);
        step();
        chk("wrap_addr", imem_addr, 32'h0);
        step();
        imem_resp = 1'b0;
        step();
        step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
